// File: rtl/e203_ifu_rs1_rdport_sched_pkg.sv
// e203_ifu_rs1_rdport_sched_pkg: shared widths and state encodings for the rs1 read-port scheduler
package e203_ifu_rs1_rdport_sched_pkg;
  localparam int XLEN = 32;
  localparam int RFIDX_W = 5;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READ = 2'd2, RSP = 2'd3} state_e;
endpackage

// File: rtl/e203_ifu_rs1_starve_cnt.sv
// e203_ifu_rs1_starve_cnt: saturating count of BPU wait cycles lost to EXU
module e203_ifu_rs1_starve_cnt
  import e203_ifu_rs1_rdport_sched_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  logic [CNT_W-1:0] cnt;
  assign sat = cnt == MAX_C;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= cnt + CNT_W'(inc & ~sat);
  end
endmodule

// File: rtl/e203_ifu_rs1_rdport_sched.sv
// e203_ifu_rs1_rdport_sched: arbitrates regfile read port rs1 between EXU decode and the IFU lite-BPU
module e203_ifu_rs1_rdport_sched
  import e203_ifu_rs1_rdport_sched_pkg::*;
#(
  parameter int XLEN = e203_ifu_rs1_rdport_sched_pkg::XLEN,
  parameter int RFIDX_W = e203_ifu_rs1_rdport_sched_pkg::RFIDX_W,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bpu_req_valid,
  output logic               bpu_req_ready,
  input  logic [RFIDX_W-1:0] bpu_req_idx,
  output logic               bpu_rsp_valid,
  input  logic               bpu_rsp_ready,
  output logic [XLEN-1:0]    bpu_rsp_data,
  input  logic               bpu_flush,
  input  logic               exu_rd_ena,
  input  logic [RFIDX_W-1:0] exu_rd_idx,
  output logic               exu_rd_stall,
  output logic               exu_rd_data_vld,
  output logic               rf_rd_ena,
  output logic [RFIDX_W-1:0] rf_rd_idx,
  input  logic [XLEN-1:0]    rf_rd_data
);
  state_e state, state_nxt;
  logic [RFIDX_W-1:0] idx;
  logic accept, grant, sat;
  assign bpu_req_ready = (state == IDLE) & ~rst & ~bpu_flush;
  assign accept = bpu_req_valid & bpu_req_ready;
  assign grant = ~rst & (state == WAIT) & (~exu_rd_ena | sat);
  assign rf_rd_ena = ~rst & (grant | exu_rd_ena);
  assign rf_rd_idx = grant ? idx : exu_rd_idx;
  assign exu_rd_stall = grant & exu_rd_ena;
  assign bpu_rsp_valid = state == RSP;
  e203_ifu_rs1_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc((state == WAIT) & ~grant),
    .clr((state == READ) | bpu_flush),
    .sat(sat)
  );
  always_comb begin
    state_nxt = bpu_flush ? IDLE
      : state == IDLE ? (accept ? (bpu_req_idx == '0 ? RSP : WAIT) : IDLE)
      : state == WAIT ? (grant ? READ : WAIT)
      : state == READ ? RSP
      : (bpu_rsp_ready ? IDLE : RSP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      bpu_rsp_data <= '0;
      exu_rd_data_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      exu_rd_data_vld <= exu_rd_ena & ~exu_rd_stall;
      if (accept) idx <= bpu_req_idx;
      if (accept && bpu_req_idx == '0) bpu_rsp_data <= '0;
      else if (state == READ && !bpu_flush) bpu_rsp_data <= rf_rd_data;
    end
  end
endmodule

// File: tb/tb_e203_ifu_rs1_rdport_sched.sv
// tb_e203_ifu_rs1_rdport_sched: directed vectors, corner sequences and random traffic against a transaction model
module tb_e203_ifu_rs1_rdport_sched;
  localparam int SM = 4;
  logic clk = 0, rst = 1;
  logic bpu_req_valid = 0, bpu_rsp_ready = 0, bpu_flush = 0, exu_rd_ena = 0;
  logic [4:0] bpu_req_idx = 0, exu_rd_idx = 0;
  logic bpu_req_ready, bpu_rsp_valid, exu_rd_stall, exu_rd_data_vld, rf_rd_ena;
  logic [4:0] rf_rd_idx;
  logic [31:0] bpu_rsp_data, rf_rd_data;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;
  bit m_pend, m_rd, m_rsp, m_exu_vld;
  int m_lost;
  logic [4:0] m_idx;
  logic [31:0] m_data;
  bit e_ready, e_grant, e_ena, e_stall;
  logic [4:0] e_idx;
  typedef struct {
    bit rv; logic [4:0] ri; bit rr, ex; logic [4:0] ei;
    bit x_ready, x_valid, x_ena; logic [4:0] x_idx; bit x_stall; logic [31:0] x_data;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  always @(posedge clk) if (rf_rd_ena) rf_rd_data <= mem[rf_rd_idx];
  e203_ifu_rs1_rdport_sched #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .bpu_req_valid(bpu_req_valid), .bpu_req_ready(bpu_req_ready), .bpu_req_idx(bpu_req_idx),
    .bpu_rsp_valid(bpu_rsp_valid), .bpu_rsp_ready(bpu_rsp_ready), .bpu_rsp_data(bpu_rsp_data),
    .bpu_flush(bpu_flush), .exu_rd_ena(exu_rd_ena), .exu_rd_idx(exu_rd_idx),
    .exu_rd_stall(exu_rd_stall), .exu_rd_data_vld(exu_rd_data_vld),
    .rf_rd_ena(rf_rd_ena), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic vec_t v(input int rv, ri, rr, ex, ei, xr, xv, xe, xi, xs, input logic [31:0] xd);
    vec_t r;
    r.rv = rv[0]; r.ri = 5'(ri); r.rr = rr[0]; r.ex = ex[0]; r.ei = 5'(ei);
    r.x_ready = xr[0]; r.x_valid = xv[0]; r.x_ena = xe[0]; r.x_idx = 5'(xi); r.x_stall = xs[0]; r.x_data = xd;
    return r;
  endfunction
  task automatic drive(input bit r, rv, input logic [4:0] ri, input bit rr, fl, ex, input logic [4:0] ei);
    rst = r; bpu_req_valid = rv; bpu_req_idx = ri; bpu_rsp_ready = rr;
    bpu_flush = fl; exu_rd_ena = ex; exu_rd_idx = ei;
    #1;
    e_ready = !r && !fl && !(m_pend || m_rd || m_rsp);
    e_grant = !r && m_pend && (!ex || m_lost == SM);
    e_ena = !r && (e_grant || ex);
    e_idx = e_grant ? m_idx : ei;
    e_stall = e_grant && ex;
    chk("req_ready", bpu_req_ready, e_ready);
    chk("rsp_valid", bpu_rsp_valid, m_rsp);
    chk("rsp_data", bpu_rsp_data, m_data);
    chk("rf_rd_ena", rf_rd_ena, e_ena);
    chk("exu_rd_stall", exu_rd_stall, e_stall);
    chk("exu_rd_data_vld", exu_rd_data_vld, m_exu_vld);
    if (e_ena) chk("rf_rd_idx", rf_rd_idx, e_idx);
  endtask
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_rd = 0; m_rsp = 0; m_lost = 0; m_data = 0; m_exu_vld = 0;
    end else begin
      m_exu_vld = exu_rd_ena && !e_stall;
      if (bpu_flush) begin
        m_pend = 0; m_rd = 0; m_rsp = 0; m_lost = 0;
      end else begin
        if (m_rd) begin
          m_data = mem[m_idx]; m_rd = 0; m_rsp = 1; m_lost = 0;
        end else if (m_rsp && bpu_rsp_ready) m_rsp = 0;
        else if (m_pend) begin
          if (e_grant) begin m_pend = 0; m_rd = 1; end
          else if (m_lost < SM) m_lost++;
        end
        if (e_ready && bpu_req_valid) begin
          m_idx = bpu_req_idx;
          if (bpu_req_idx == 0) begin m_rsp = 1; m_data = 0; end
          else m_pend = 1;
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    int k;
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'h0 : $urandom;
    mem[5] = 32'h1234_5678;
    mem[7] = 32'h0bad_f00d;
    m_pend = 0; m_rd = 0; m_rsp = 0; m_lost = 0; m_data = 0; m_exu_vld = 0; m_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) begin
      drive(1, 1, 5'd5, 0, 0, 1, 5'd2);
      chk("rst_ready", bpu_req_ready, 1'b0);
      chk("rst_rf_ena", rf_rd_ena, 1'b0);
      adv();
    end
    tbl.push_back(v(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h1234_5678));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 7, 0, 1, 3, 1, 0, 1, 3, 0, 0));
    repeat (4) tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, 1, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, 1, 7, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 3, 0, 0, 1, 3, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 3, 0, 1, 1, 3, 0, 32'h0bad_f00d));
    tbl.push_back(v(0, 0, 0, 1, 3, 1, 0, 1, 3, 0, 0));
    foreach (tbl[i]) begin
      drive(0, tbl[i].rv, tbl[i].ri, tbl[i].rr, 0, tbl[i].ex, tbl[i].ei);
      chk($sformatf("vec%0d_ready", i), bpu_req_ready, tbl[i].x_ready);
      chk($sformatf("vec%0d_valid", i), bpu_rsp_valid, tbl[i].x_valid);
      chk($sformatf("vec%0d_ena", i), rf_rd_ena, tbl[i].x_ena);
      chk($sformatf("vec%0d_stall", i), exu_rd_stall, tbl[i].x_stall);
      if (tbl[i].x_ena) chk($sformatf("vec%0d_idx", i), rf_rd_idx, tbl[i].x_idx);
      if (tbl[i].x_valid) chk($sformatf("vec%0d_data", i), bpu_rsp_data, tbl[i].x_data);
      adv();
    end
    drive(0, 1, 5'd9, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0); adv();
    repeat (3) begin
      drive(0, 1, 5'd4, 0, 0, 0, 0);
      chk("bp_valid", bpu_rsp_valid, 1'b1);
      chk("bp_data", bpu_rsp_data, mem[9]);
      chk("bp_ready", bpu_req_ready, 1'b0);
      adv();
    end
    drive(0, 1, 5'd4, 1, 0, 0, 0);
    chk("bp_hs_ready", bpu_req_ready, 1'b0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("bp_after_ready", bpu_req_ready, 1'b1);
    chk("bp_after_valid", bpu_rsp_valid, 1'b0);
    adv();
    drive(0, 1, 5'd11, 0, 0, 1, 5'd2); adv();
    drive(0, 0, 0, 0, 0, 1, 5'd2); adv();
    drive(0, 0, 0, 0, 1, 1, 5'd2); adv();
    drive(0, 1, 5'd12, 0, 0, 1, 5'd2);
    chk("flw_ready", bpu_req_ready, 1'b1);
    chk("flw_valid", bpu_rsp_valid, 1'b0);
    adv();
    k = 0;
    for (int c = 1; c < 10; c++) begin
      drive(0, 0, 0, 1, 0, 1, 5'd2);
      if (exu_rd_stall && k == 0) k = c;
      adv();
    end
    chk("flw_starve_restart", k, 5);
    drive(0, 1, 5'd0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("flr_valid_before", bpu_rsp_valid, 1'b1);
    adv();
    drive(0, 1, 5'd13, 0, 0, 0, 0);
    chk("flr_valid", bpu_rsp_valid, 1'b0);
    chk("flr_ready", bpu_req_ready, 1'b1);
    adv();
    repeat (4) begin drive(0, 0, 0, 1, 0, 0, 0); adv(); end
    drive(0, 1, 5'd14, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rr_valid", bpu_rsp_valid, 1'b0);
    chk("rr_data", bpu_rsp_data, 32'h0);
    chk("rr_ena", rf_rd_ena, 1'b0);
    chk("rr_ready", bpu_req_ready, 1'b1);
    adv();
    repeat (3) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      chk("rr_stays_idle", bpu_rsp_valid, 1'b0);
      adv();
    end
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) == 0, $urandom_range(2) == 0,
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(1) == 1,
            $urandom_range(19) == 0, $urandom_range(2) != 0, 5'($urandom));
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
